// File: rtl/composite_decoder_if.sv
// Composite decoder sample/result bundle: one composite input sample per clock and the
// per-window luma/chroma results plus sync pulses and line count.
interface composite_decoder_if;
    logic [5:0] composite;
    logic [5:0] luma;
    logic       chroma_present;
    logic       sample_valid;
    logic       hsync;
    logic       vsync;
    logic [8:0] line_count;

    modport master (
        output composite,
        input  luma,
        input  chroma_present,
        input  sample_valid,
        input  hsync,
        input  vsync,
        input  line_count
    );

    modport slave (
        input  composite,
        output luma,
        output chroma_present,
        output sample_valid,
        output hsync,
        output vsync,
        output line_count
    );
endinterface

// File: rtl/composite_decoder.sv
// Composite receive path: per-carrier-period min/max reduction into luma and chroma flag,
// plus a sync-run FSM producing hsync/vsync and a line count. Optional COMPOSITE_DECODER_BLANK_EN.
module composite_decoder #(
    parameter int unsigned HSYNC_MIN_WIN = 8,
    parameter int unsigned VSYNC_MIN_WIN = 64,
    parameter int unsigned SYNC_LEVEL    = 4,
    parameter int unsigned CHROMA_THRESH = 8
) (
    input logic                clk_142mhz,
    input logic                reset,
    composite_decoder_if.slave bus
);

    localparam logic [6:0] SyncLevel    = 7'(SYNC_LEVEL);
    localparam logic [6:0] ChromaThresh = 7'(CHROMA_THRESH);
    localparam logic [7:0] HsyncMin     = 8'(HSYNC_MIN_WIN);
    localparam logic [7:0] VsyncMin     = 8'(VSYNC_MIN_WIN);
    localparam logic [7:0] RunMax       = 8'd255;
    localparam logic [8:0] LineMax      = 9'd511;
    localparam logic [4:0] PhaseLast    = 5'd31;

    // ---------------------------------------------------------------- window reduction
    logic [4:0] phase_q, phase_d;
    logic [5:0] min_q, min_d;
    logic [5:0] max_q, max_d;
    logic [5:0] luma_q, luma_d;
    logic       chroma_q, chroma_d;
    logic       valid_q, valid_d;
    logic       win_sync_q, win_sync_d;

    logic [5:0] fin_min;
    logic [5:0] fin_max;
    logic [5:0] swing;
    logic       win_sync;
    logic       win_chroma;

    always_comb begin
        fin_min    = (bus.composite < min_q) ? bus.composite : min_q;
        fin_max    = (bus.composite > max_q) ? bus.composite : max_q;
        swing      = fin_max - fin_min;
        win_sync   = {1'b0, fin_min} < SyncLevel;
        win_chroma = {1'b0, swing} >= ChromaThresh;

        phase_d    = phase_q + 5'd1;
        min_d      = fin_min;
        max_d      = fin_max;
        luma_d     = luma_q;
        chroma_d   = chroma_q;
        valid_d    = 1'b0;
        win_sync_d = win_sync_q;

        if (phase_q == 5'd0) begin
            min_d = bus.composite;
            max_d = bus.composite;
        end

        if (phase_q == PhaseLast) begin
            valid_d    = 1'b1;
            win_sync_d = win_sync;
`ifdef COMPOSITE_DECODER_BLANK_EN
            luma_d     = win_sync ? 6'd0 : fin_min;
            chroma_d   = win_sync ? 1'b0 : win_chroma;
`else
            luma_d     = fin_min;
            chroma_d   = win_chroma;
`endif
        end
    end

    always_ff @(posedge clk_142mhz) begin
        if (reset) begin
            phase_q    <= 5'd0;
            min_q      <= 6'd63;
            max_q      <= 6'd0;
            luma_q     <= 6'd0;
            chroma_q   <= 1'b0;
            valid_q    <= 1'b0;
            win_sync_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            min_q      <= min_d;
            max_q      <= max_d;
            luma_q     <= luma_d;
            chroma_q   <= chroma_d;
            valid_q    <= valid_d;
            win_sync_q <= win_sync_d;
        end
    end

    // ---------------------------------------------------------------- sync run FSM
    typedef enum logic [0:0] {StActive, StSync} sync_state_e;

    sync_state_e state_q;
    logic [7:0]  run_q;
    logic [7:0]  run_inc;
    logic        hsync_q;
    logic        vsync_q;
    logic [8:0]  line_count_q;

    assign run_inc = (run_q == RunMax) ? run_q : run_q + 8'd1;

    // The window flags in valid_q/win_sync_q are already registered, so the FSM acts one
    // cycle after the window closes and its pulses land in the cycle after sample_valid.
    always_ff @(posedge clk_142mhz) begin
        if (reset) begin
            state_q      <= StActive;
            run_q        <= 8'd0;
            hsync_q      <= 1'b0;
            vsync_q      <= 1'b0;
            line_count_q <= 9'd0;
        end else begin
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
            if (valid_q) begin
                unique case (state_q)
                    StActive: begin
                        if (win_sync_q) begin
                            state_q <= StSync;
                            run_q   <= 8'd1;
                        end
                    end
                    StSync: begin
                        if (win_sync_q) begin
                            run_q <= run_inc;
                            // A saturated run never re-fires: run_inc only equals run_q at 255.
                            if (run_inc == VsyncMin && run_q != VsyncMin) begin
                                vsync_q      <= 1'b1;
                                line_count_q <= 9'd0;
                            end
                        end else begin
                            state_q <= StActive;
                            run_q   <= 8'd0;
                            if (run_q >= HsyncMin && run_q < VsyncMin) begin
                                hsync_q      <= 1'b1;
                                line_count_q <= (line_count_q == LineMax) ? line_count_q
                                                                          : line_count_q + 9'd1;
                            end
                        end
                    end
                    default: begin
                        state_q <= StActive;
                        run_q   <= 8'd0;
                    end
                endcase
            end
        end
    end

    assign bus.luma           = luma_q;
    assign bus.chroma_present = chroma_q;
    assign bus.sample_valid   = valid_q;
    assign bus.hsync          = hsync_q;
    assign bus.vsync          = vsync_q;
    assign bus.line_count     = line_count_q;

endmodule
